fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
- Parametrised successor to the pipeline's combinational forwarding logic, with sequential state.
- Tracks in-flight destination registers in an internal scoreboard shift register of DEPTH stages.
- Each cycle it compares the ID-stage instruction's sources against that scoreboard. It then registers EX-aligned operand select codes, and raises a load-use stall and EX bubble when forwarding cannot cover the hazard.
- Sits beside the ID/EX pipeline register. Its outputs drive the EX operand muxes and the IF/ID hold logic.

Parameters:
- REG_W, 5, register index width.
- DEPTH, 2, number of forwarding sources after EX (1 = EX/MEM, 2 = MEM/WB, ...). Must be >= 2.
- ZERO_REG, 31, hard-wired zero register. Never tracked, never forwarded.
- SEL_W, $clog2(DEPTH+1), width of the select codes.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- hold_i  in  1  global pipeline freeze (e.g. memory wait); all state holds.
- flush_i  in  1  squash the ID-stage instruction (taken branch).
- id_valid_i  in  1  ID holds a real instruction.
- id_rn_i  in  REG_W  first source register.
- id_rm_i  in  REG_W  second source register; also store-data register.
- id_use_rn_i  in  1  instruction reads Rn.
- id_use_rm_i  in  1  instruction reads Rm (register operand or store data).
- id_wr_en_i  in  1  instruction writes a register.
- id_wr_reg_i  in  REG_W  destination register.
- id_is_load_i  in  1  instruction is a load.
- stall_o  out  1  combinational. Hold PC and IF/ID this cycle.
- fwd_sel_a_o  out  SEL_W  registered. Rn source for the instruction now in EX: 0 = register file, k = stage-k source.
- fwd_sel_b_o  out  SEL_W  registered. Same encoding, for Rm.
- ex_bubble_o  out  1  registered. EX holds a bubble.

Behaviour:
- Scoreboard:
  - Entries 1..DEPTH, each {valid, reg, is_load}.
  - Entry 1 is the instruction now in EX; entry k is k-1 stages older.
- Reset (asynchronous, reset_n low):
  - All entries invalid.
  - fwd_sel_a_o = fwd_sel_b_o = 0.
  - ex_bubble_o = 1.
  - stall_o = 0 while in reset.
- Match rule for source s (Rn or Rm), evaluated against the current scoreboard:
  - Entry k matches when: use_s, id_valid_i, entry valid, entry.reg == s, and s != ZERO_REG.
  - The lowest-k match wins (youngest producer).
  - No match gives 0.
- Load-use hazard:
  - Raised when id_valid_i and either source's winning match is entry 1 with is_load = 1.
  - stall_o = hazard & ~flush_i & ~hold_i.
- Clock edge with hold_i = 1: every register holds, including the scoreboard and outputs. hold_i has priority over flush_i and stall.
- Clock edge with hold_i = 0:
  - Entries 2..DEPTH load entries 1..DEPTH-1; the oldest entry is discarded.
  - Entry 1 loads the ID instruction {id_wr_en_i & id_wr_reg_i != ZERO_REG, id_wr_reg_i, id_is_load_i}, unless id_valid_i = 0, flush_i = 1 or stall_o = 1. In those cases entry 1 loads invalid.
  - fwd_sel_a_o / fwd_sel_b_o load the winning k for Rn / Rm. They load 0 when entry 1 gets a bubble.
  - ex_bubble_o loads 1 when entry 1 gets a bubble (invalid, flushed or stalled), else 0.
- Timing consequences:
  - Stall lasts exactly 1 cycle per load-use pair. After the bubble, the load sits in entry 2, the consumer re-evaluates, and it gets sel = 2 with no stall.
  - Latency from ID inputs to select outputs is 1 cycle.
- Boundary cases:
  - A destination equal to ZERO_REG is stored invalid.
  - Both sources matching the same register get the same select.
  - A producer older than DEPTH is not forwarded; the register file is written before it is read.
  - reset_n deasserting mid-stall: the unit restarts empty, with no residual stall.

Optional Feature:
- Macro: FWD_HAZ_PERF_EN.
- Defined:
  - Adds output ports fwd_cnt_o [31:0] and stall_cnt_o [31:0], reset to 0.
  - fwd_cnt_o increments by 1 on each non-held edge where a non-bubble instruction enters EX with a nonzero select on A or B (counts once even if both).
  - stall_cnt_o increments on each non-held edge with stall_o = 1.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and counters are absent. All other behaviour is identical.

Test Plan:
1. Reset, then issue ADD X1←X2,X3, then SUB X4←X1,X5 next cycle -> on SUB in EX: fwd_sel_a_o = 1, fwd_sel_b_o = 0, ex_bubble_o = 0, stall_o never asserts.
2. Producer X2, then an unrelated instruction, then consumer of X2 (Rm) -> fwd_sel_b_o = 2. Producer X2 followed by 3 unrelated instructions -> fwd_sel_b_o = 0.
3. LDUR X7, then ADD X8←X7,X7 -> stall_o = 1 for exactly one cycle; next edge ex_bubble_o = 1; following edge fwd_sel_a_o = fwd_sel_b_o = 2, ex_bubble_o = 0.
4. X9 written by two consecutive instructions, then read -> select = 1 (youngest). Writer to X31 followed by reader of X31 -> select = 0.
5. Load-use hazard with flush_i = 1 the same cycle -> stall_o = 0, ex_bubble_o = 1, consumer not tracked. Hazard with hold_i = 1 for 3 cycles -> outputs and stall unchanged throughout, stall resolves one edge after hold_i drops.
6. reset_n pulsed low during a stall cycle -> outputs immediately read sel 0 / bubble 1 / stall 0. With FWD_HAZ_PERF_EN, scenario 3 yields stall_cnt_o = 1 and fwd_cnt_o = 1.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit: operand forwarding select and load-use hazard detection.
// A DEPTH-stage scoreboard shadows the destinations of the instructions in
// EX and later stages. Each cycle the ID-stage sources are matched against
// it. The unit then registers EX-aligned forwarding selects and raises a
// one-cycle load-use stall when a load result is not yet available.
// Optional build macro FWD_HAZ_PERF_EN adds saturating forward/stall counters.

module fwd_hazard_unit #(
  parameter int REG_W    = 5,
  parameter int DEPTH    = 2,
  parameter int ZERO_REG = 31,
  parameter int SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rn_i,
  input  logic [REG_W-1:0] id_rm_i,
  input  logic             id_use_rn_i,
  input  logic             id_use_rm_i,
  input  logic             id_wr_en_i,
  input  logic [REG_W-1:0] id_wr_reg_i,
  input  logic             id_is_load_i,
  output logic             stall_o,
  output logic [SEL_W-1:0] fwd_sel_a_o,
  output logic [SEL_W-1:0] fwd_sel_b_o,
  output logic             ex_bubble_o
`ifdef FWD_HAZ_PERF_EN
  ,
  output logic [31:0]      fwd_cnt_o,
  output logic [31:0]      stall_cnt_o
`endif
);

  localparam logic [REG_W-1:0] ZERO_IDX = REG_W'(ZERO_REG);

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] rd;
    logic             is_load;
  } sb_entry_t;

  // Entry 1 is the instruction now in EX; entry k is k-1 stages older.
  sb_entry_t        sb [1:DEPTH];
  sb_entry_t        id_entry;
  logic [SEL_W-1:0] win_a;
  logic [SEL_W-1:0] win_b;
  logic             hazard;
  logic             bubble;

  // Youngest matching producer for each source; 0 means read the register file.
  always_comb begin
    // NOTE: defaults first so every path assigns win_a/win_b and no latch is inferred.
    win_a = '0;
    win_b = '0;
    // Walk oldest to youngest so the lowest matching k is the last one written.
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_valid_i && id_use_rn_i && (id_rn_i != ZERO_IDX) &&
          sb[k].valid && (sb[k].rd == id_rn_i))
        win_a = SEL_W'(k);
      if (id_valid_i && id_use_rm_i && (id_rm_i != ZERO_IDX) &&
          sb[k].valid && (sb[k].rd == id_rm_i))
        win_b = SEL_W'(k);
    end
  end

  // A load in EX cannot be forwarded to the very next instruction.
  assign hazard  = id_valid_i && sb[1].is_load &&
                   ((win_a == SEL_W'(1)) || (win_b == SEL_W'(1)));
  assign stall_o = hazard & ~flush_i & ~hold_i;
  assign bubble  = ~id_valid_i | flush_i | stall_o;

  // What the ID instruction looks like once it enters EX.
  always_comb begin
    id_entry.valid   = ~bubble & id_wr_en_i & (id_wr_reg_i != ZERO_IDX);
    id_entry.rd      = id_wr_reg_i;
    id_entry.is_load = ~bubble & id_is_load_i;
  end

  // Scoreboard shift and EX-aligned select/bubble registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the scoreboard is a handful of flops whose valid bits gate all
      // matching, so it is reset like any other control state, not left as memory.
      for (int k = 1; k <= DEPTH; k++) sb[k] <= '0;
      fwd_sel_a_o <= '0;
      fwd_sel_b_o <= '0;
      ex_bubble_o <= 1'b1;
    end else if (!hold_i) begin
      // NOTE: non-blocking assignments let every stage read its neighbour's
      // pre-edge value, so the shift order inside the loop does not matter.
      for (int k = DEPTH; k >= 2; k--) sb[k] <= sb[k-1];
      sb[1]       <= id_entry;
      fwd_sel_a_o <= bubble ? '0 : win_a;
      fwd_sel_b_o <= bubble ? '0 : win_b;
      ex_bubble_o <= bubble;
    end
  end

`ifdef FWD_HAZ_PERF_EN
  logic fwd_event;
  assign fwd_event = ~bubble & ((win_a != '0) | (win_b != '0));

  // Saturating counts of forwarded instructions and stall cycles.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fwd_cnt_o   <= '0;
      stall_cnt_o <= '0;
    end else if (!hold_i) begin
      if (fwd_event && (fwd_cnt_o != 32'hFFFF_FFFF))
        fwd_cnt_o <= fwd_cnt_o + 32'd1;
      if (stall_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// tb_fwd_hazard_unit: directed scenarios plus randomized traffic, all checked
// against a queue-based model of the in-flight instruction history.
// Define FWD_HAZ_PERF_EN to also check the performance counters.

module tb_fwd_hazard_unit;

  localparam int REG_W    = 5;
  localparam int DEPTH    = 2;
  localparam int ZERO_REG = 31;
  localparam int SEL_W    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset_n;
  logic             hold_i, flush_i, id_valid_i;
  logic [REG_W-1:0] id_rn_i, id_rm_i, id_wr_reg_i;
  logic             id_use_rn_i, id_use_rm_i, id_wr_en_i, id_is_load_i;
  logic             stall_o, ex_bubble_o;
  logic [SEL_W-1:0] fwd_sel_a_o, fwd_sel_b_o;
`ifdef FWD_HAZ_PERF_EN
  logic [31:0]      fwd_cnt_o, stall_cnt_o;
`endif

  fwd_hazard_unit #(.REG_W(REG_W), .DEPTH(DEPTH), .ZERO_REG(ZERO_REG)) dut (
    .clk(clk), .reset_n(reset_n), .hold_i(hold_i), .flush_i(flush_i),
    .id_valid_i(id_valid_i), .id_rn_i(id_rn_i), .id_rm_i(id_rm_i),
    .id_use_rn_i(id_use_rn_i), .id_use_rm_i(id_use_rm_i),
    .id_wr_en_i(id_wr_en_i), .id_wr_reg_i(id_wr_reg_i),
    .id_is_load_i(id_is_load_i), .stall_o(stall_o),
    .fwd_sel_a_o(fwd_sel_a_o), .fwd_sel_b_o(fwd_sel_b_o),
    .ex_bubble_o(ex_bubble_o)
`ifdef FWD_HAZ_PERF_EN
    , .fwd_cnt_o(fwd_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  // Model: history of what entered EX, youngest first, always DEPTH long.
  typedef struct {
    bit v;
    int r;
    bit ld;
  } ent_t;

  ent_t        hist[$];
  int          exp_a, exp_b, exp_bub;
  int unsigned exp_fc, exp_sc;
  bit          last_stall;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string tag, input longint unsigned got,
                       input longint unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int youngest(input bit valid, input bit use_s, input int s);
    int w = 0;
    if (valid && use_s && s != ZERO_REG)
      for (int k = 0; k < DEPTH; k++)
        if (w == 0 && hist[k].v && hist[k].r == s) w = k + 1;
    return w;
  endfunction

  task automatic model_reset();
    ent_t e = '{v: 1'b0, r: 0, ld: 1'b0};
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(e);
    exp_a = 0; exp_b = 0; exp_bub = 1; exp_fc = 0; exp_sc = 0;
  endtask

  task automatic check_regs(input string tag);
    check({tag, "_sel_a"}, fwd_sel_a_o, exp_a);
    check({tag, "_sel_b"}, fwd_sel_b_o, exp_b);
    check({tag, "_bubble"}, ex_bubble_o, exp_bub);
`ifdef FWD_HAZ_PERF_EN
    check({tag, "_fwd_cnt"}, fwd_cnt_o, exp_fc);
    check({tag, "_stall_cnt"}, stall_cnt_o, exp_sc);
`endif
  endtask

  task automatic drive(input bit v, input int rn, input int rm, input bit urn,
                       input bit urm, input bit we, input int wr, input bit ld,
                       input bit fl, input bit hd);
    id_valid_i = v; id_rn_i = REG_W'(rn); id_rm_i = REG_W'(rm);
    id_use_rn_i = urn; id_use_rm_i = urm; id_wr_en_i = we;
    id_wr_reg_i = REG_W'(wr); id_is_load_i = ld; flush_i = fl; hold_i = hd;
  endtask

  // One cycle: drive at negedge, check stall, clock, check registered outputs.
  task automatic step(input string tag, input bit v, input int rn, input int rm,
                      input bit urn, input bit urm, input bit we, input int wr,
                      input bit ld, input bit fl, input bit hd);
    int   wa, wb;
    bit   hz, bub;
    ent_t e;
    @(negedge clk);
    drive(v, rn, rm, urn, urm, we, wr, ld, fl, hd);
    #1;
    wa = youngest(v, urn, rn);
    wb = youngest(v, urm, rm);
    hz = v && hist[0].ld && (wa == 1 || wb == 1);
    last_stall = hz && !fl && !hd;
    check({tag, "_stall"}, stall_o, last_stall);
    @(posedge clk);
    if (!hd) begin
      bub = !v || fl || last_stall;
      e.v  = !bub && we && (wr != ZERO_REG);
      e.r  = wr;
      e.ld = !bub && ld;
      hist.push_front(e);
      hist = hist[0:DEPTH-1];
      exp_a   = bub ? 0 : wa;
      exp_b   = bub ? 0 : wb;
      exp_bub = bub;
      if (!bub && (wa != 0 || wb != 0) && exp_fc != 32'hFFFF_FFFF) exp_fc++;
      if (last_stall && exp_sc != 32'hFFFF_FFFF) exp_sc++;
    end
    #1;
    check_regs(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #1;
    check("reset_stall", stall_o, 0);
    check_regs("reset");
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_reset();
    #12;
    check("por_stall", stall_o, 0);
    check_regs("por");
    reset_n = 1'b1;

    // 1: ADD X1<-X2,X3 then SUB X4<-X1,X5 forwards A from EX/MEM.
    step("t1_add", 1, 2, 3, 1, 1, 1, 1, 0, 0, 0);
    step("t1_sub", 1, 1, 5, 1, 1, 1, 4, 0, 0, 0);
    check("t1_sel_a_is_1", fwd_sel_a_o, 1);
    check("t1_sel_b_is_0", fwd_sel_b_o, 0);

    // 2: producer X2, one unrelated, consumer Rm=X2 -> 2; with 3 unrelated -> 0.
    step("t2_prod", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    step("t2_unrel", 1, 0, 0, 0, 0, 1, 10, 0, 0, 0);
    step("t2_cons", 1, 6, 2, 1, 1, 1, 12, 0, 0, 0);
    check("t2_sel_b_is_2", fwd_sel_b_o, 2);
    step("t2_prod2", 1, 0, 0, 0, 0, 1, 2, 0, 0, 0);
    for (int i = 0; i < 3; i++) step("t2_unrel", 1, 0, 0, 0, 0, 1, 13 + i, 0, 0, 0);
    step("t2_cons2", 1, 6, 2, 1, 1, 1, 12, 0, 0, 0);
    check("t2_sel_b_is_0", fwd_sel_b_o, 0);

    // 3: LDUR X7 then ADD X8<-X7,X7: one stall, bubble, then sel 2/2.
    do_reset();
    step("t3_ldur", 1, 0, 0, 1, 0, 1, 7, 1, 0, 0);
    step("t3_add", 1, 7, 7, 1, 1, 1, 8, 0, 0, 0);
    check("t3_stalled", last_stall, 1);
    check("t3_bubble_is_1", ex_bubble_o, 1);
    step("t3_add_retry", 1, 7, 7, 1, 1, 1, 8, 0, 0, 0);
    check("t3_no_restall", last_stall, 0);
    check("t3_sel_a_is_2", fwd_sel_a_o, 2);
    check("t3_sel_b_is_2", fwd_sel_b_o, 2);
`ifdef FWD_HAZ_PERF_EN
    check("t3_stall_cnt_is_1", stall_cnt_o, 1);
    check("t3_fwd_cnt_is_1", fwd_cnt_o, 1);
`endif

    // 4: X9 written twice then read -> 1; X31 written then read -> 0.
    step("t4_w9a", 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step("t4_w9b", 1, 0, 0, 0, 0, 1, 9, 0, 0, 0);
    step("t4_r9", 1, 9, 9, 1, 1, 1, 3, 0, 0, 0);
    check("t4_sel_a_is_1", fwd_sel_a_o, 1);
    step("t4_w31", 1, 0, 0, 0, 0, 1, 31, 0, 0, 0);
    step("t4_r31", 1, 31, 31, 1, 1, 1, 3, 0, 0, 0);
    check("t4_sel_zero", fwd_sel_a_o, 0);

    // 5: load-use with flush, then load-use under a 3-cycle hold.
    step("t5_ldur", 1, 0, 0, 1, 0, 1, 7, 1, 0, 0);
    step("t5_flush", 1, 7, 0, 1, 0, 1, 8, 0, 1, 0);
    check("t5_flush_bubble", ex_bubble_o, 1);
    step("t5_read8", 1, 8, 0, 1, 0, 1, 4, 0, 0, 0);
    step("t5_ldur2", 1, 0, 0, 1, 0, 1, 7, 1, 0, 0);
    for (int i = 0; i < 3; i++) step("t5_hold", 1, 7, 0, 1, 0, 1, 8, 0, 0, 1);
    step("t5_release", 1, 7, 0, 1, 0, 1, 8, 0, 0, 0);
    check("t5_stall_after_hold", last_stall, 1);
    step("t5_retry", 1, 7, 0, 1, 0, 1, 8, 0, 0, 0);

    // 6: reset asserted in the middle of a stall cycle.
    step("t6_ldur", 1, 0, 0, 1, 0, 1, 7, 1, 0, 0);
    @(negedge clk);
    drive(1, 7, 7, 1, 1, 1, 8, 0, 0, 0);
    #1;
    check("t6_pre_stall", stall_o, 1);
    reset_n = 1'b0;
    model_reset();
    #1;
    check("t6_rst_stall", stall_o, 0);
    check_regs("t6_rst");
    @(negedge clk);
    reset_n = 1'b1;
    step("t6_after", 1, 7, 7, 1, 1, 1, 8, 0, 0, 0);

    // Randomized traffic over a small register set to provoke many matches.
    for (int i = 0; i < 3000; i++) begin
      int pick[5] = '{1, 2, 3, 4, 31};
      step("rand",
           ($urandom_range(9) != 0),
           pick[$urandom_range(4)], pick[$urandom_range(4)],
           $urandom_range(1), $urandom_range(1), $urandom_range(1),
           pick[$urandom_range(4)], ($urandom_range(2) == 0),
           ($urandom_range(11) == 0), ($urandom_range(7) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
